// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
// Contents: funct3 access-size codes, FSM state type, and helper functions
// for legality, alignment and byte-enable generation.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data alignment and extension.
// Ports:
//   rdata  in  32  raw bus word
//   off    in  2   byte offset of the access within the word
//   funct3 in  3   access size / signedness
//   data   out 32  lane-selected, sign- or zero-extended result
module load_extend
  import mau_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed lane down to bit 0; W accesses are aligned so off is 0.
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a single-cycle core data port and a handshaked bus.
// Optional feature macro: MAU_TIMEOUT_EN (enables a BUS-state watchdog sized
// by TIMEOUT_CYCLES that aborts the access with err=1).
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_we/req_funct3/req_addr/req_wdata  core request
//   stall      hold the core while the access is outstanding
//   rdata      extended load result, valid in DONE
//   err        one-cycle pulse: illegal, misaligned or timed out
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata       bus request
//   bus_ack/bus_rdata                              bus response
//   dbg_state  current FSM state
//
// Bus handshake: bus_req rises on entry to BUS and every bus output stays
// constant until the cycle bus_ack is sampled high; that cycle completes the
// transfer (bus_rdata is captured then) and bus_req is low from the next cycle.
module mem_access_unit
  import mau_pkg::*;
  #(parameter int unsigned TIMEOUT_CYCLES = 256)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  mau_state_t  state_q, state_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] ext_data;
  logic        req_ok;
  logic        accept;
  logic        expire;
`ifdef MAU_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif

  assign req_ok = f3_legal(req_we, req_funct3) & ~addr_misaligned(req_funct3, req_addr[1:0]);
  assign accept = (state_q == IDLE) & req_valid & req_ok;

`ifdef MAU_TIMEOUT_EN
  // An ack in the last allowed cycle takes priority over expiry.
  assign expire = (state_q == BUS) & ~bus_ack & (cnt_q == TIMEOUT_CYCLES - 1);
`else
  assign expire = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata  (bus_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
`ifdef MAU_TIMEOUT_EN
      cnt_q       <= 32'h0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
`ifdef MAU_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS:     if (bus_ack || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
`ifdef MAU_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
`endif
    if (accept) begin
      bus_we_d   = req_we;
      bus_addr_d = {req_addr[31:2], 2'b00};
      bus_be_d   = byte_enables(req_funct3, req_addr[1:0]);
      off_d      = req_addr[1:0];
      f3_d       = req_funct3;
      case (req_funct3)
        F3_B:    bus_wdata_d = {4{req_wdata[7:0]}};
        F3_H:    bus_wdata_d = {2{req_wdata[15:0]}};
        default: bus_wdata_d = req_wdata;
      endcase
`ifdef MAU_TIMEOUT_EN
      cnt_d = 32'h0;
`endif
    end
    if (state_q == BUS) begin
`ifdef MAU_TIMEOUT_EN
      cnt_d = cnt_q + 32'd1;
`endif
      if (bus_ack) begin
        rdata_d = bus_we_q ? 32'h0 : ext_data;
      end else if (expire) begin
        rdata_d = 32'h0;
`ifdef MAU_TIMEOUT_EN
        tmo_d   = 1'b1;
`endif
      end
    end
  end

  // Outputs.
  always_comb begin
    // DONE releases the core for its single completion cycle.
    stall   = req_valid & req_ok & (state_q != DONE);
    bus_req = (state_q == BUS);
    err     = (state_q == IDLE) & req_valid & ~req_ok;
`ifdef MAU_TIMEOUT_EN
    err     = err | tmo_q;
`endif
  end

  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized accesses
// checked against an arithmetic reference model. Build with +define+MAU_TIMEOUT_EN
// to also exercise the watchdog with TIMEOUT_CYCLES=4.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall;
  logic [31:0] rdata;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  localparam int TMO = 4;
`ifdef MAU_TIMEOUT_EN
  localparam int MAX_DLY = TMO - 1;
`else
  localparam int MAX_DLY = 6;
`endif

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rdata      (rdata),
    .err        (err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return legal && ((addr % size_of(f3)) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    int be;
    sz = size_of(f3);
    be = ((1 << sz) - 1) << addr[1:0];
    return be[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int sz;
    logic [31:0] mask;
    logic [31:0] v;
    sz   = size_of(f3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rd >> (8 * addr[1:0])) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called between a rising edge and the following falling edge; returns at
  // 1 time unit after a rising edge. dly = number of BUS cycles before the
  // ack cycle (0 = ack on first BUS cycle), -1 = never ack.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int dly,
                           input string tag);
    logic        ok;
    logic [71:0] exp_bus;
    logic [71:0] got_bus;
    logic [31:0] exp_rd;
    int          stall_cnt;
    bit          timed_out;
    bit          ended;
    ok = model_ok(we, f3, addr);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    if (!ok) begin
      check({tag, "_err"}, err, 1);
      check({tag, "_stall"}, stall, 0);
      check({tag, "_busreq"}, bus_req, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, "_busreq_after"}, bus_req, 0);
      @(posedge clk); #1;
      return;
    end
    exp_q.push_back(we ? 32'h0 : model_load(f3, addr, rd));
    exp_bus = {2'b00, 1'b1, we, model_be(f3, addr), {addr[31:2], 2'b00},
               (we ? model_wdata(f3, wd) : 32'h0)};
    check({tag, "_idle_err"}, err, 0);
    check({tag, "_idle_busreq"}, bus_req, 0);
    stall_cnt = int'(stall);
    timed_out = 1'b0;
    ended     = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) begin
      bus_ack   = (k == dly);
      bus_rdata = (k == dly) ? rd : $urandom;
      @(negedge clk);
      got_bus = {2'b00, bus_req, bus_we, bus_be, bus_addr, (we ? bus_wdata : 32'h0)};
      check({tag, "_bus"}, got_bus, exp_bus);
      stall_cnt += int'(stall);
      if (k == dly) begin
        ended = 1'b1;
        break;
      end
`ifdef MAU_TIMEOUT_EN
      if (k == TMO - 1) begin
        timed_out = 1'b1;
        ended     = 1'b1;
        break;
      end
`endif
      @(posedge clk); #1;
    end
    if (!ended) check({tag, "_bus_wait_bound"}, 0, 1);
    @(posedge clk); #1;
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    @(negedge clk);
    exp_rd = exp_q.pop_front();
    if (timed_out) exp_rd = 32'h0;
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_done_stall"}, stall, 0);
    check({tag, "_done_err"}, err, timed_out);
    check({tag, "_done_busreq"}, bus_req, 0);
    check({tag, "_done_state"}, dbg_state, 2);
    check({tag, "_stall_cycles"}, stall_cnt, timed_out ? 1 + TMO_OR(0) : dly + 2);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  function automatic int TMO_OR(input int dflt);
`ifdef MAU_TIMEOUT_EN
    return TMO;
`else
    return dflt;
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_bus"}, {bus_req, bus_we, bus_be, bus_addr, bus_wdata}, 70'h0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    int          d;

    // Reset held low: all outputs at their reset values.
    #12;
    check_reset_values("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // bus_ack while IDLE is ignored.
    bus_ack = 1'b1;
    @(negedge clk);
    check("idle_ack_busreq", bus_req, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_state", dbg_state, 0);
    @(posedge clk); #1;

    // Directed cases.
    do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, "t1_lb");
    do_access(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 0, "t2_sh");
    do_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, "t3_lw_mis");
    d = (MAX_DLY < 5) ? MAX_DLY : 5;
    do_access(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hF00D_0000, d, "t4_lhu");
    do_access(1'b0, 3'b001, 32'h0000_0006, 32'h0, 32'h8001_0002, 1, "lh_hi");
    do_access(1'b0, 3'b100, 32'h0000_0011, 32'h0, 32'h0000_9A00, 0, "lbu");
    do_access(1'b1, 3'b000, 32'h0000_0031, 32'h1234_56A5, 32'h0, 2, "sb");
    do_access(1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 0, "sw");
    do_access(1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, "sbu_illegal");
    do_access(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, "f3_011_illegal");
    do_access(1'b0, 3'b111, 32'h0000_0000, 32'h0, 32'h0, 0, "f3_111_illegal");
    do_access(1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0, "lh_mis");
    do_access(1'b1, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 0, "sh_mis");

    // Reset asserted mid-transfer.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0080;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_busreq_before", bus_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busreq_async", bus_req, 0);
    check("rst_mid_state_async", dbg_state, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid_after");
    @(posedge clk); #1;

`ifdef MAU_TIMEOUT_EN
    do_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, -1, "t6_timeout");
    do_access(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, TMO - 1, "t6_ack_last");
`endif

    // Randomized accesses.
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && (f == 3'd3 || f >= 3'd6)) f = 3'd2;
      do_access(1'($urandom_range(0, 1)), f, a, $urandom, $urandom,
                $urandom_range(0, MAX_DLY), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
